des_dec_key_sched: RTL and testbench

Iterative DES key scheduler for the decryption direction of the TDES datapath. It accepts a 64-bit key and emits the sixteen 48-bit round subkeys in reverse order, K16 first and K1 last, one per accepted handshake. It feeds the round function that consumes the S-box lookups, so the same round hardware can run decryption.

---
 rtl/des_dec_key_sched.sv | 109 ++++++++++
 tb/tb_des_dec_key_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/des_dec_key_sched.sv
// Iterative DES decryption key schedule: loads a 64-bit key and emits K16..K1,
// one 48-bit subkey per accepted valid/ready handshake.
module des_dec_key_sched #(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic        key_ready,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk_out,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        parity_err
);

    typedef enum logic {IDLE, EMIT} state_t;

    // Tables hold 1-based DES bit numbers (bit 1 is the MSB of each vector).
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    // Decryption walks the schedule backwards, so the encrypt-side left
    // rotation becomes a right rotation.
    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    state_t      state;
    logic [27:0] c, d;
    logic [3:0]  rnd;
    logic        two_step;
    logic        par_bad;

    // s(rnd+1) is 1 only for rounds 1, 2, 9 and 16.
    assign two_step = !(rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15);

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < 8; b++)
            par_bad = par_bad | ~(^key_in[8*b +: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            c          <= '0;
            d          <= '0;
            rnd        <= '0;
            parity_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_load) begin
                        {c, d}     <= pc1(key_in);
                        rnd        <= 4'hF;
                        parity_err <= CHECK_PARITY ? par_bad : 1'b0;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (sk_ready) begin
                        c <= rotr(c, two_step);
                        d <= rotr(d, two_step);
                        if (rnd == 4'd0) state <= IDLE;
                        else             rnd   <= rnd - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_ready = (state == IDLE);
    assign sk_valid  = (state == EMIT);
    assign sk_out    = pc2({c, d});
    assign sk_round  = rnd;
    assign sk_last   = sk_valid && (rnd == 4'd0);

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Directed bench for des_dec_key_sched using the classic 133457799BBCDFF1 key.
module tb_des_dec_key_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        key_load;
    logic        key_ready;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk_out;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        parity_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    // Subkeys in emission order: K16 down to K1.
    logic [47:0] exp_sk [0:15] = '{
        48'hCB3D8B0E17F5, 48'hBF918D3D3F0A, 48'h5F43B7F2E73A, 48'h97C5D1FABA41,
        48'h7571F59467E9, 48'h215FD3DED386, 48'hB1F347BA464F, 48'hE0DBEBEDE781,
        48'hF78A3AC13BFB, 48'hEC84B7F618BC, 48'h63A53E507B2F, 48'h7CEC07EB53A8,
        48'h72ADD6DB351D, 48'h55FC8A42CF99, 48'h79AED9DBC9E5, 48'h1B02EFFC7072
    };

    des_dec_key_sched #(.CHECK_PARITY(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
        .key_ready  (key_ready),
        .sk_valid   (sk_valid),
        .sk_ready   (sk_ready),
        .sk_out     (sk_out),
        .sk_round   (sk_round),
        .sk_last    (sk_last),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    // Checks subkeys first..15 with sk_ready high, one per cycle.
    task automatic run_from(input int first, input bit zero_key, input string tag);
        for (int i = first; i < 16; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 64'(sk_valid), 64'd1);
            chk($sformatf("%s_sk%0d", tag, i), 64'(sk_out), zero_key ? 64'd0 : 64'(exp_sk[i]));
            chk($sformatf("%s_rnd%0d", tag, i), 64'(sk_round), 64'(15 - i));
            chk($sformatf("%s_last%0d", tag, i), 64'(sk_last), 64'(i == 15));
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        key_in   = KEY;
        key_load = 1'b1;
        sk_ready = 1'b1;

        // Reset held with key_load high: nothing loads.
        step();
        step();
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_sk_valid", 64'(sk_valid), 64'd0);
        chk("rst_sk_out", 64'(sk_out), 64'd0);
        chk("rst_sk_round", 64'(sk_round), 64'd0);
        chk("rst_sk_last", 64'(sk_last), 64'd0);
        chk("rst_parity", 64'(parity_err), 64'd0);
        rst      = 1'b0;
        key_load = 1'b0;
        step();

        // Free-running run.
        load(KEY);
        chk("free_parity", 64'(parity_err), 64'd0);
        run_from(0, 1'b0, "free");
        chk("free_end_ready", 64'(key_ready), 64'd1);
        chk("free_end_valid", 64'(sk_valid), 64'd0);

        // Back-to-back load with backpressure and an ignored load in EMIT.
        sk_ready = 1'b0;
        load(KEY);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_sk%0d", i), 64'(sk_out), 64'(exp_sk[0]));
            chk($sformatf("bp_hold_rnd%0d", i), 64'(sk_round), 64'hF);
            chk($sformatf("bp_hold_ready%0d", i), 64'(key_ready), 64'd0);
            if (i == 2) begin
                key_in   = 64'h0;
                key_load = 1'b1;
            end
            step();
            key_load = 1'b0;
        end
        chk("ign_parity", 64'(parity_err), 64'd0);
        sk_ready = 1'b1;
        run_from(0, 1'b0, "bp");
        chk("bp_end_ready", 64'(key_ready), 64'd1);

        // Reset after the 7th subkey has been accepted.
        load(KEY);
        for (int i = 0; i < 7; i++) step();
        chk("mid_pre_sk", 64'(sk_out), 64'(exp_sk[7]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_valid", 64'(sk_valid), 64'd0);
        chk("mid_ready", 64'(key_ready), 64'd1);
        chk("mid_sk_out", 64'(sk_out), 64'd0);
        load(KEY);
        run_from(0, 1'b0, "reload");

        // Parity: all-zero key has even-parity bytes, still processed.
        load(64'h0);
        chk("par_zero_err", 64'(parity_err), 64'd1);
        run_from(0, 1'b1, "zero");
        chk("par_sticky", 64'(parity_err), 64'd1);
        load(KEY);
        chk("par_clear", 64'(parity_err), 64'd0);
        chk("par_clear_sk", 64'(sk_out), 64'(exp_sk[0]));
        run_from(0, 1'b0, "final");
        chk("final_ready", 64'(key_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
